// File: rtl/mem_size_pkg.sv
// mem_size_pkg: size encoding and load FSM states shared by the load and store size paths
package mem_size_pkg;
    typedef enum logic [1:0] {
        SZ_INV  = 2'b00,
        SZ_WORD = 2'b01,
        SZ_HALF = 2'b10,
        SZ_BYTE = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EXTRACT,
        DONE
    } state_t;
endpackage

// File: rtl/load_extract.sv
// load_extract: selects word/half/byte from the MDR and zero- or sign-extends to 32 bits
module load_extract
    import mem_size_pkg::*;
(
    input  logic [31:0] mdr,
    input  size_t       size,
    input  logic        sign_ext,
    output logic [31:0] result
);
    assign result = size == SZ_WORD ? mdr :
                    size == SZ_HALF ? {{16{sign_ext & mdr[15]}}, mdr[15:0]} :
                    size == SZ_BYTE ? {{24{sign_ext & mdr[7]}}, mdr[7:0]} :
                    32'd0;
endmodule

// File: rtl/load_size_unit.sv
// load_size_unit: issues one memory read per request, waits out the read latency and
// returns the sized, extended result for register-file write-back
module load_size_unit
    import mem_size_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  ls_control,
    input  logic        sign_ext,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_out
);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    size_t              size_q;
    logic               sign_q;
    logic [31:0]        mdr;
    logic [31:0]        ext;

    load_extract u_extract (
        .mdr      (mdr),
        .size     (size_q),
        .sign_ext (sign_q),
        .result   (ext)
    );

    assign busy = state != IDLE;

    // mem_addr doubles as the latched request address
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            size_q   <= SZ_INV;
            sign_q   <= 1'b0;
            mdr      <= '0;
            mem_read <= 1'b0;
            mem_addr <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            load_out <= '0;
        end else begin
            mem_read <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        size_q <= size_t'(ls_control);
                        sign_q <= sign_ext;
                        if (size_t'(ls_control) == SZ_INV) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            load_out <= '0;
                        end else begin
                            state    <= REQ;
                            mem_read <= 1'b1;
                            mem_addr <= addr;
                        end
                    end
                end
                REQ: begin
                    cnt   <= CNT_W'(MEM_LATENCY);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        mdr   <= mem_rdata;
                        state <= EXTRACT;
                    end
                end
                EXTRACT: begin
                    load_out <= ext;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_size_unit.md
Name: load_size_unit

Overview:
- Read-side counterpart of the store size-merge path.
- Sequences one memory read per request, waits out the memory's read latency, and registers the returned word (the MDR copy).
- Extracts word, halfword or byte from bits [31:0], [15:0] or [7:0], then zero- or sign-extends it to 32 bits for the register-file write-back mux.
- Uses the same 2-bit size encoding as the store path: 01 word, 10 halfword, 11 byte.

Parameters:
- MEM_LATENCY, default 1: cycles from the cycle mem_read is asserted to the cycle mem_rdata is valid. Legal range 1..15.
- CNT_W, default 4: width of the wait counter. Must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request pulse; sampled only in IDLE or DONE
- addr  input  32  byte address of the load
- ls_control  input  2  01 word, 10 halfword, 11 byte, 00 invalid
- sign_ext  input  1  1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu); ignored for word
- mem_read  output  1  memory read strobe, one cycle per request
- mem_addr  output  32  address driven to memory
- mem_rdata  input  32  memory read data
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  high with done when ls_control was 00
- load_out  output  32  sized and extended result; held until the next completion

Behaviour:
- Reset: the only reset is the synchronous, active-high reset on clk. It forces the following:
  - state IDLE, counter 0, latched address/size/sign 0, internal MDR 0.
  - All outputs 0: mem_read, mem_addr, busy, done, err, load_out.
- Reset mid-operation: reset wins over every other event. Any in-flight read is abandoned and any mem_rdata arriving later is ignored.
- States:
  - IDLE: if start, latch addr, ls_control and sign_ext. Next state is REQ, or DONE with err if ls_control is 00.
  - REQ: mem_read=1 and mem_addr=addr_q for exactly this cycle. Load counter with MEM_LATENCY; next state WAIT.
  - WAIT: counter decrements each cycle. On the cycle the counter reaches 1, capture mem_rdata into the MDR; next state EXTRACT.
  - EXTRACT: register load_out from the MDR per the size and sign rules; next state DONE.
  - DONE: done=1 for one cycle. If start is asserted in DONE, it is accepted exactly as in IDLE (back-to-back loads). Otherwise the next state is IDLE.
- mem_addr holds addr_q from REQ until the next accepted request.
- Latency: start sampled in cycle 0 gives REQ in cycle 1 and done in cycle MEM_LATENCY+3. With MEM_LATENCY=1, done is in cycle 4.
- Extraction rules:
  - Word: load_out = MDR.
  - Halfword: {16{sign_ext & MDR[15]}, MDR[15:0]}.
  - Byte: {24{sign_ext & MDR[7]}, MDR[7:0]}.
- No alignment check. The memory returns the 4 bytes starting at addr, which mirrors the low-bit merge on the store side.
- Invalid size (00):
  - No mem_read is issued; the unit goes IDLE to DONE.
  - done=1 and err=1 in the DONE cycle; load_out is set to 0.
- err is 0 on every valid completion.
- start asserted in REQ, WAIT or EXTRACT is ignored and not queued.
- load_out changes only on the EXTRACT-to-DONE edge, on an invalid completion, or on reset.

Decomposition:
- Shared package mem_size_pkg, which the store size-merge block will also import, holds:
  - typedef enum logic [1:0] size_t {SZ_INV=2'b00, SZ_WORD=2'b01, SZ_HALF=2'b10, SZ_BYTE=2'b11}.
  - The state enum {IDLE, REQ, WAIT, EXTRACT, DONE}.
- Sub-module load_extract: purely combinational (MDR, size, sign_ext in; 32-bit result out). It is instantiated once and registered in EXTRACT.

Test Plan:
- Reset then idle: all outputs 0 for 5 cycles. Then reset=0 with no start: outputs stay 0 and mem_read is never asserted.
- Word load, MEM_LATENCY=1: addr=0x100, ls_control=01, mem_rdata=0xDEADBEEF.
  - mem_read in cycle 1 with mem_addr=0x100.
  - done in cycle 4 with load_out=0xDEADBEEF and err=0.
- Signed halfword: MDR 0x1234F00D, ls_control=10. sign_ext=1 gives load_out=0xFFFFF00D; sign_ext=0 gives 0x0000F00D.
- Byte loads on MDR 0xAABBCC80 with ls_control=11:
  - sign_ext=1 gives load_out=0xFFFFFF80; sign_ext=0 gives 0x00000080.
  - Re-run with MEM_LATENCY=3: done lands in cycle 6.
- Invalid size and busy protection:
  - ls_control=00: done=1 and err=1 in cycle 1, mem_read never asserted, load_out=0.
  - A start pulse during WAIT is ignored: exactly one mem_read and one done are produced.
- Back-to-back and reset:
  - start held in the DONE cycle: the second REQ follows immediately after DONE.
  - reset asserted during WAIT: next cycle state is IDLE with all outputs 0, and no done follows.
